// File: rtl/phase_c_sequencer.sv
// -----------------------------------------------------------------------------
// phase_c_sequencer
//
// Drives one full Montgomery A*B product through the phase_c iteration stage.
// B is consumed as NUM_DIGITS radix-bit digits, least significant first. For
// each digit the sequencer issues (c, a, bi) with a single-cycle ph_en strobe,
// waits for ph_en_out, then shifts the returned c right by RADIX and reuses it
// as the next pass's c. An 8-bit watchdog aborts a pass that never answers.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      product request, honoured only when idle
//   a_in       in   SIZE   multiplicand, captured on accepted start
//   b_in       in   SIZE   multiplier, captured on accepted start
//   busy       out  1      high from the cycle after accept through done
//   done       out  1      one-cycle pulse: product finished or aborted
//   error      out  1      watchdog expired; sticky until next accepted start
//   result     out  C_W    final c, valid from done until next accepted start
//   ph_c       out  C_W    running c to phase_c
//   ph_a       out  SIZE   captured a to phase_c
//   ph_bi      out  RADIX  current digit of B
//   ph_en      out  1      one-cycle issue strobe to phase_c
//   ph_new_c   in   C_W    phase_c result
//   ph_en_out  in   1      phase_c result strobe
// -----------------------------------------------------------------------------
module phase_c_sequencer #(
  parameter int SIZE     = 3072,
  parameter int RADIX    = 72,
  parameter int SIZE_LOG = 6,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [SIZE-1:0]              a_in,
  input  logic [SIZE-1:0]              b_in,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [SIZE+RADIX+SIZE_LOG-1:0] result,
  output logic [SIZE+RADIX+SIZE_LOG-1:0] ph_c,
  output logic [SIZE-1:0]              ph_a,
  output logic [RADIX-1:0]             ph_bi,
  output logic                         ph_en,
  input  logic [SIZE+RADIX+SIZE_LOG-1:0] ph_new_c,
  input  logic                         ph_en_out
);

  localparam int C_W        = SIZE + RADIX + SIZE_LOG;
  localparam int NUM_DIGITS = (SIZE + RADIX - 1) / RADIX;
  localparam int B_W        = NUM_DIGITS * RADIX;
  localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WD_W       = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SHIFT,
    S_FIN
  } state_e;

  state_e             state_q;
  logic [DIG_W-1:0]   digit_q;
  logic [WD_W-1:0]    wd_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;
  logic [C_W-1:0]     result_q;
  logic [C_W-1:0]     ph_c_q;
  logic [SIZE-1:0]    ph_a_q;
  logic [RADIX-1:0]   ph_bi_q;
  logic               ph_en_q;

  // B is held as a shift register: the digit in use always sits at the
  // bottom, so the next digit is a fixed slice rather than a wide mux.
  logic [B_W-1:0]     b_q;
  logic [C_W-1:0]     new_c_q;

  wire last_digit = (digit_q == DIG_W'(NUM_DIGITS - 1));

  // NOTE: b_q and new_c_q are wide datapath registers that are always written
  // before they are read, so they carry no reset; that keeps thousands of
  // flops off the reset tree. Every control and output register is reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      b_q <= B_W'(b_in);             // zero-pads the top digit above SIZE
    end else if (state_q == S_SHIFT) begin
      b_q <= b_q >> RADIX;
    end
    if (state_q == S_WAIT && ph_en_out) begin
      new_c_q <= ph_new_c;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      digit_q  <= '0;
      wd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      ph_c_q   <= '0;
      ph_a_q   <= '0;
      ph_bi_q  <= '0;
      ph_en_q  <= 1'b0;
    end else begin
      // Strobes default low; only the transitions below raise them.
      done_q  <= 1'b0;
      ph_en_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ph_a_q  <= a_in;
            ph_bi_q <= b_in[RADIX-1:0];
            ph_c_q  <= '0;
            digit_q <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            ph_en_q <= 1'b1;          // strobe lines up with the ISSUE cycle
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          // A response in the final watchdog cycle still wins over timeout.
          if (ph_en_out) begin
            state_q <= S_SHIFT;
          end else if (wd_q == WD_W'(TIMEOUT)) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        S_SHIFT: begin
          ph_c_q <= new_c_q >> RADIX;
          if (last_digit) begin
            result_q <= new_c_q >> RADIX;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end else begin
            digit_q <= digit_q + 1'b1;
            // b_q still holds the current digit at the bottom this cycle.
            ph_bi_q <= b_q[2*RADIX-1:RADIX];
            ph_en_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end

        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;
  assign ph_c   = ph_c_q;
  assign ph_a   = ph_a_q;
  assign ph_bi  = ph_bi_q;
  assign ph_en  = ph_en_q;

endmodule

// File: tb/tb_phase_c_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_c_sequencer
//
// Surrounds phase_c_sequencer with a behavioural phase_c (new_c = c + a*bi,
// answered LAT cycles after the issue cycle) and a transaction-level
// expectation of when strobes, done and busy must appear. Final products are
// also compared against a plain digit-by-digit golden computation.
// -----------------------------------------------------------------------------
module tb_phase_c_sequencer;

  localparam int SIZE    = 3072;
  localparam int RADIX   = 72;
  localparam int C_W     = 3150;
  localparam int ND      = 43;
  localparam int TIMEOUT = 255;
  localparam int LAT     = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [SIZE-1:0]  a_in;
  logic [SIZE-1:0]  b_in;
  logic             busy, done, error, ph_en;
  logic [C_W-1:0]   result, ph_c;
  logic [SIZE-1:0]  ph_a;
  logic [RADIX-1:0] ph_bi;
  logic [C_W-1:0]   ph_new_c;
  logic             ph_en_out;

  always #5 clk = ~clk;

  phase_c_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .result    (result),
    .ph_c      (ph_c),
    .ph_a      (ph_a),
    .ph_bi     (ph_bi),
    .ph_en     (ph_en),
    .ph_new_c  (ph_new_c),
    .ph_en_out (ph_en_out)
  );

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_wide(input string name, input logic [C_W-1:0] act, input logic [C_W-1:0] exp);
    int fb;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      fb = -1;
      for (int i = 0; i < C_W; i++) begin
        if (act[i] !== exp[i]) begin
          fb = i;
          break;
        end
      end
      $display("FAIL %s: got low64 %h, expected low64 %h, first differing bit %0d (cycle %0d)",
               name, act[63:0], exp[63:0], fb, cyc);
    end
  endtask

  function automatic logic [SIZE-1:0] rand_wide();
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Golden product: c starts at 0; for each LSD-first digit, c = (c + a*digit) >> RADIX.
  function automatic logic [C_W-1:0] golden(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [C_W-1:0]      c;
    logic [ND*RADIX-1:0] bb;
    c  = '0;
    bb = (ND*RADIX)'(b);
    for (int d = 0; d < ND; d++) c = (c + C_W'(a) * C_W'(bb[d*RADIX +: RADIX])) >> RADIX;
    return c;
  endfunction

  // ---------------- behavioural phase_c ----------------
  logic           mdl_out = 1'b0;
  logic [C_W-1:0] mdl_c   = '0;
  logic [C_W-1:0] resp    = '0;
  logic           inj_out = 1'b0;
  logic [C_W-1:0] inj_c   = '0;
  bit             mute    = 1'b0;
  bit             pend    = 1'b0;
  bit             seen    = 1'b0;
  int             cnt     = 0;

  assign ph_en_out = mdl_out | inj_out;
  assign ph_new_c  = inj_out ? inj_c : mdl_c;

  initial begin
    forever begin
      @(negedge clk);
      seen = ph_en;
      if (ph_en) resp = ph_c + C_W'(ph_a) * C_W'(ph_bi);
      @(posedge clk);
      #1;
      mdl_out = 1'b0;
      if (seen && !mute) begin
        pend = 1'b1;
        cnt  = LAT;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mdl_out = 1'b1;
          mdl_c   = resp;
          pend    = 1'b0;
        end
      end
    end
  end

  // ---------------- transaction-level expectation + compare ----------------
  bit              act = 1'b0, was_act = 1'b0, waiting = 1'b0;
  bit              err_pend = 1'b0, err_exp = 1'b0, res_valid = 1'b1;
  longint          en_at = -1, done_at = -1, issued_at = 0;
  longint          accept_cyc = 0, done_cyc = 0;
  int              k = 0, en_pulses = 0, done_count = 0;
  logic [C_W-1:0]  c_run = '0, res_exp = '0;
  logic [SIZE-1:0] a_exp = '0, b_exp = '0;
  logic [RADIX-1:0] bi_log [ND];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_ph_en", 64'(ph_en), 64'd0);
      check("rst_ph_bi", 64'(ph_bi), 64'd0);
      check_wide("rst_result", result, '0);
      check_wide("rst_ph_c", ph_c, '0);
      check_wide("rst_ph_a", C_W'(ph_a), '0);
      act = 1'b0; waiting = 1'b0; en_at = -1; done_at = -1; k = 0;
      err_exp = 1'b0; err_pend = 1'b0; a_exp = '0; res_exp = '0; res_valid = 1'b1;
    end else begin
      was_act = act;
      if (cyc == done_at) begin
        err_exp = err_pend;
        if (!err_pend) begin
          res_exp   = c_run;
          res_valid = 1'b1;
        end
      end

      check("busy", 64'(busy), 64'(act));
      check("ph_en", 64'(ph_en), 64'(cyc == en_at));
      check("done", 64'(done), 64'(cyc == done_at));
      check("error", 64'(error), 64'(err_exp));
      check_wide("ph_a", C_W'(ph_a), C_W'(a_exp));
      if (res_valid) check_wide("result", result, res_exp);

      if (ph_en) begin
        check_wide("ph_bi", C_W'(ph_bi), C_W'(RADIX'(b_exp >> (k * RADIX))));
        check_wide("ph_c", ph_c, c_run);
        if (k < ND) bi_log[k] = ph_bi;
        en_pulses++;
        waiting   = 1'b1;
        issued_at = cyc;
      end else if (waiting) begin
        if (ph_en_out) begin
          waiting = 1'b0;
          c_run   = ph_new_c >> RADIX;
          k++;
          if (k == ND) done_at = cyc + 2;
          else         en_at   = cyc + 2;
        end else if (cyc == issued_at + TIMEOUT + 1) begin
          waiting  = 1'b0;
          err_pend = 1'b1;
          done_at  = cyc + 1;
        end
      end

      if (cyc == done_at) begin
        act = 1'b0;
        done_count++;
        done_cyc = cyc;
      end

      if (!was_act && start) begin
        act = 1'b1; en_at = cyc + 1; done_at = -1; k = 0; c_run = '0;
        a_exp = a_in; b_exp = b_in; err_pend = 1'b0; err_exp = 1'b0;
        res_valid = 1'b0; accept_cyc = cyc; en_pulses = 0; waiting = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_count;
    for (int i = 0; i < budget && done_count == d0; i++) tick();
    if (done_count == d0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_wait: no done within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  task automatic run_product(input string tag, input logic [SIZE-1:0] a,
                             input logic [SIZE-1:0] b, input bit inj_issue);
    start = 1'b1; a_in = a; b_in = b;
    tick();
    start = 1'b0; a_in = rand_wide(); b_in = rand_wide();
    if (inj_issue) begin
      inj_out = 1'b1; inj_c = C_W'(rand_wide());
      tick();
      inj_out = 1'b0;
    end
    wait_done(2000);
    check({tag, "_pulses"}, 64'(en_pulses), 64'(ND));
    check({tag, "_latency"}, 64'(done_cyc - accept_cyc + 1), 64'(1 + ND * (3 + LAT) + 1));
    check({tag, "_error"}, 64'(error), 64'd0);
    check_wide({tag, "_golden"}, result, golden(a, b));
  endtask

  initial begin
    logic [SIZE-1:0] a1, b1, a_top;
    logic [C_W-1:0]  pin;
    int              d0, p;
    longint          first_done;

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Pin the golden model with hand-derived values.
    a1 = '0; a1[0] = 1'b1;
    b1 = '0; b1[SIZE-1] = 1'b1; b1[2] = 1'b1; b1[0] = 1'b1;
    check_wide("pin_golden_t1", golden(a1, b1), '0);
    a_top = '0; a_top[SIZE-1] = 1'b1;
    pin = '0; pin[3046] = 1'b1;      // 2^3071 * 2^47 >> 72
    check_wide("pin_golden_top", golden(a_top, a_top), pin);

    // T1: a = 1, b = 2^3071 | 5
    run_product("t1", a1, b1, 1'b0);
    check("t1_bi0", 64'(bi_log[0]), 64'd5);
    check_wide("t1_bi42", C_W'(bi_log[42]), C_W'(72'h800000000000));
    check("t1_latency_lit", 64'(done_cyc - accept_cyc + 1), 64'd862);
    check_wide("t1_result_lit", result, '0);

    // T2: start held high for the whole busy window
    a1 = rand_wide(); b1 = rand_wide();
    start = 1'b1; a_in = a1; b_in = b1;
    tick();
    d0 = done_count;
    for (int i = 0; i < 2000 && done_count == d0; i++) begin
      start = busy;
      a_in  = rand_wide();
      b_in  = rand_wide();
      tick();
    end
    start = 1'b0;
    check("t2_done_seen", 64'(done_count), 64'(d0 + 1));
    check("t2_pulses", 64'(en_pulses), 64'(ND));
    check_wide("t2_golden", result, golden(a1, b1));
    repeat (20) tick();
    check("t2_single_done", 64'(done_count), 64'(d0 + 1));

    // T3: phase_c never answers
    mute = 1'b1;
    start = 1'b1; a_in = rand_wide(); b_in = rand_wide();
    tick();
    start = 1'b0;
    wait_done(600);
    check("t3_error", 64'(error), 64'd1);
    check("t3_wait_to_done", 64'(done_cyc - (accept_cyc + 2)), 64'd256);
    check("t3_busy_low", 64'(busy), 64'd0);
    check("t3_pulses", 64'(en_pulses), 64'd1);
    mute = 1'b0;
    repeat (3) tick();

    // T4: the next start clears error; then reset during digit 10's WAIT
    start = 1'b1; a_in = rand_wide(); b_in = rand_wide();
    tick();
    start = 1'b0;
    check("t3_error_cleared", 64'(error), 64'd0);
    for (int i = 0; i < 600 && en_pulses < 11; i++) tick();
    check("t4_reached_digit10", 64'(en_pulses), 64'd11);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("t4_async_busy", 64'(busy), 64'd0);
    check("t4_async_ph_en", 64'(ph_en), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    p = en_pulses;
    repeat (40) tick();
    check("t4_no_en_after_reset", 64'(en_pulses), 64'(p));
    check("t4_idle", 64'(busy), 64'd0);

    // T5: stray ph_en_out in IDLE, then in ISSUE
    d0 = done_count;
    inj_out = 1'b1; inj_c = C_W'(rand_wide());
    tick();
    inj_out = 1'b0;
    repeat (4) tick();
    check("t5_idle_busy", 64'(busy), 64'd0);
    check("t5_idle_done", 64'(done_count), 64'(d0));
    run_product("t5", rand_wide(), rand_wide(), 1'b1);

    // T6: two products back to back, the second at full operand width
    repeat (2) tick();
    run_product("t6a", rand_wide(), rand_wide(), 1'b0);
    first_done = done_cyc;
    run_product("t6b", '1, '1, 1'b0);
    check("t6_back_to_back", 64'(accept_cyc - first_done), 64'd1);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
